prog_loader: RTL and testbench

- Upstream program-load stage for the SAP-2 mini CPU.
- Receives a framed byte stream over a valid/ready interface and assembles 12-bit words. Drives the CPU's program-mode inputs (prog, a, d) and a one-cycle RAM write strobe per word.
- Holds the CPU in reset until a frame has been loaded and its checksum verified, then releases it.
- Replaces manual switch loading of the 256x12 program RAM.

---
 rtl/prog_loader_pkg.sv | 31 +++
 rtl/prog_loader_byte_timer.sv | 35 +++
 rtl/prog_loader.sv | 179 +++++++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants for the SAP-2 program loader: sync marker, FSM encoding,
// frame field order and checksum width.
package prog_loader_pkg;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Checksum accumulator width (mod-256 sum)
    localparam int CHK_W = 8;

    // FSM encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_CNT  = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_HI   = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_CHK  = 3'd6;

    // Frame field order: SYNC, ADDR, CNT, then CNT (LO,HI) pairs, then CHK
    localparam int FLD_SYNC  = 0;
    localparam int FLD_ADDR  = 1;
    localparam int FLD_CNT   = 2;
    localparam int FLD_WORDS = 3;

    // High byte is legal when every bit above the word width is zero
    function automatic logic hi_bits_ok(input logic [7:0] hi, input int dw);
        hi_bits_ok = ((hi >> (dw - 8)) == 8'd0);
    endfunction

endpackage

// File: rtl/prog_loader_byte_timer.sv
// Inter-byte timeout: reloads to TIMEOUT on clear, counts down while enabled,
// flags expiry at zero. TIMEOUT=0 disables the expired flag entirely.
module byte_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic clr,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: reload on clear, saturate at zero while counting
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = LOAD;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - TW'(1);
    end

    // Counter register; reset corresponds to an elapsed time of zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt_q <= LOAD;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader for the SAP-2: parses framed bytes into RAM writes, holds
// the CPU in reset until a frame's checksum verifies, then releases it.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = 1000,
    parameter int         AW        = 8,
    parameter int         DW        = 12
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          prog,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d,
    output logic          we,
    output logic          cpu_clr,
    output logic          done,
    output logic          err
);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [DW-1:0]    d_q, d_d;
    logic [8:0]       rem_q, rem_d;     // words left; 256 needs 9 bits
    logic [CHK_W-1:0] sum_q, sum_d;
    logic [CHK_W-1:0] sum_nx;
    logic             prog_q, prog_d;
    logic             cpu_clr_q, cpu_clr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             acc;
    logic             in_frame;
    logic             tmo_clear;
    logic             tmo_exp;

    // Only S_WR stalls the stream; it owns the write strobe
    assign in_ready = (state_q != S_WR);
    assign we       = (state_q == S_WR);
    assign acc      = in_valid & in_ready;
    assign sum_nx   = sum_q + in_data;
    assign in_frame = (state_q == S_ADDR) || (state_q == S_CNT) || (state_q == S_LO) ||
                      (state_q == S_HI)   || (state_q == S_CHK);

    // Timer is idle outside a frame and during the write cycle
    assign tmo_clear = acc || (state_q == S_IDLE) || (state_q == S_WR);

    byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .clr       (clr),
        .clear_i   (tmo_clear),
        .en_i      (~tmo_clear),
        .expired_o (tmo_exp)
    );

    // Frame parser: next-state, address/data/count and checksum updates
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        rem_d     = rem_q;
        sum_d     = sum_q;
        prog_d    = prog_q;
        cpu_clr_d = cpu_clr_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (acc && (in_data == SYNC_BYTE)) begin
                    state_d   = S_ADDR;
                    prog_d    = 1'b1;
                    cpu_clr_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    sum_d     = '0;
                end
            end
            S_ADDR: begin
                if (acc) begin
                    a_d     = AW'(in_data);
                    sum_d   = sum_nx;
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (acc) begin
                    rem_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    sum_d   = sum_nx;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (acc) begin
                    d_d[7:0] = in_data;
                    sum_d    = sum_nx;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (acc) begin
                    if (!hi_bits_ok(in_data, DW)) begin
                        state_d = S_IDLE;
                        prog_d  = 1'b0;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        d_d[DW-1:8] = in_data[DW-9:0];
                        sum_d       = sum_nx;
                        state_d     = S_WR;
                    end
                end
            end
            S_WR: begin
                a_d     = a_q + AW'(1);
                rem_d   = rem_q - 9'd1;
                state_d = (rem_q == 9'd1) ? S_CHK : S_LO;
            end
            S_CHK: begin
                if (acc) begin
                    state_d = S_IDLE;
                    prog_d  = 1'b0;
                    if (sum_nx == '0) begin
                        cpu_clr_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled frame aborts regardless of what else happened this cycle
        if (in_frame && tmo_exp) begin
            state_d = S_IDLE;
            prog_d  = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            d_q       <= '0;
            rem_q     <= '0;
            sum_q     <= '0;
            prog_q    <= 1'b0;
            cpu_clr_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            rem_q     <= rem_d;
            sum_q     <= sum_d;
            prog_q    <= prog_d;
            cpu_clr_q <= cpu_clr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign prog    = prog_q;
    assign a       = a_q;
    assign d       = d_q;
    assign cpu_clr = cpu_clr_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed checksums.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, prog, we, cpu_clr, done, err;
    logic [7:0]  a;
    logic [11:0] d;

    int checks = 0;
    int errors = 0;
    int rdy_bad = 0;
    int both_bad = 0;
    logic [7:0]  wa[$];
    logic [11:0] wd[$];

    prog_loader dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prog(prog), .a(a), .d(d), .we(we),
        .cpu_clr(cpu_clr), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log writes and handshake/flag invariants mid-cycle
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa.push_back(a);
            wd.push_back(d);
        end
        if (!clr && (in_ready === we)) rdy_bad++;
        if (done === 1'b1 && err === 1'b1) both_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Drive one byte, optionally after idle cycles; returns #1 after transfer edge
    task automatic send_byte(input logic [7:0] b, input int gap = 0);
        int guard = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 20) begin
            checks++; errors++;
            $display("FAIL send_ready: in_ready=%b, required 1 within 20 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #12;
        checks++; if (prog !== 1'b0)    begin errors++; $display("FAIL rst_prog: got %b want 0", prog); end
        checks++; if (a !== 8'h00)      begin errors++; $display("FAIL rst_a: got %h want 00", a); end
        checks++; if (d !== 12'h000)    begin errors++; $display("FAIL rst_d: got %h want 000", d); end
        checks++; if (we !== 1'b0)      begin errors++; $display("FAIL rst_we: got %b want 0", we); end
        checks++; if (cpu_clr !== 1'b1) begin errors++; $display("FAIL rst_cpu_clr: got %b want 1", cpu_clr); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [7:0] f[6] = '{8'hA5, 8'h10, 8'h01, 8'h34, 8'h02, 8'hB9};
        wa.delete(); wd.delete();
        foreach (f[i]) send_byte(f[i]);
        checks++; if (wa.size() != 1) begin errors++; $display("FAIL single_cnt: got %0d writes want 1", wa.size()); end
        else begin
            checks++; if (wa[0] !== 8'h10)  begin errors++; $display("FAIL single_a: got %h want 10", wa[0]); end
            checks++; if (wd[0] !== 12'h234) begin errors++; $display("FAIL single_d: got %h want 234", wd[0]); end
        end
        checks++; if (prog !== 1'b0)    begin errors++; $display("FAIL single_prog: got %b want 0", prog); end
        checks++; if (cpu_clr !== 1'b0) begin errors++; $display("FAIL single_cpu_clr: got %b want 0", cpu_clr); end
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL single_done: got %b want 1", done); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    // Reload while running: SYNC reasserts cpu_clr on its accept edge
    task automatic test_reload();
        logic [7:0] f[5] = '{8'h30, 8'h01, 8'h55, 8'h03, 8'h77};
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        checks++; if (cpu_clr !== 1'b1) begin errors++; $display("FAIL reload_cpu_clr: got %b want 1", cpu_clr); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reload_done: got %b want 0", done); end
        checks++; if (prog !== 1'b1)    begin errors++; $display("FAIL reload_prog: got %b want 1", prog); end
        foreach (f[i]) send_byte(f[i]);
        checks++; if (wa.size() != 1 || wa[0] !== 8'h30 || wd[0] !== 12'h355) begin
            errors++; $display("FAIL reload_write: got %0d writes, want one at 30=355", wa.size());
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done2: got %b want 1", done); end
    endtask

    task automatic test_bad_chk();
        logic [7:0] f[6] = '{8'hA5, 8'h10, 8'h01, 8'h34, 8'h02, 8'hB8};
        wa.delete(); wd.delete();
        foreach (f[i]) send_byte(f[i]);
        checks++; if (wa.size() != 1 || wa[0] !== 8'h10) begin errors++; $display("FAIL badchk_write: got %0d writes, want one at 10", wa.size()); end
        checks++; if (err !== 1'b1)     begin errors++; $display("FAIL badchk_err: got %b want 1", err); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL badchk_done: got %b want 0", done); end
        checks++; if (cpu_clr !== 1'b1) begin errors++; $display("FAIL badchk_cpu_clr: got %b want 1", cpu_clr); end
        checks++; if (prog !== 1'b0)    begin errors++; $display("FAIL badchk_prog: got %b want 0", prog); end
    endtask

    task automatic test_wrap();
        logic [7:0] f[8] = '{8'hA5, 8'hFF, 8'h02, 8'h11, 8'h00, 8'h22, 8'h01, 8'hCB};
        wa.delete(); wd.delete();
        foreach (f[i]) send_byte(f[i]);
        checks++; if (wa.size() != 2) begin errors++; $display("FAIL wrap_cnt: got %0d writes want 2", wa.size()); end
        else begin
            checks++; if (wa[0] !== 8'hFF || wd[0] !== 12'h011) begin errors++; $display("FAIL wrap_w0: got %h=%h want FF=011", wa[0], wd[0]); end
            checks++; if (wa[1] !== 8'h00 || wd[1] !== 12'h122) begin errors++; $display("FAIL wrap_w1: got %h=%h want 00=122", wa[1], wd[1]); end
        end
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wrap_flags: got done=%b err=%b want 1 0", done, err); end
    endtask

    // CNT=0: 256 words, LO=index, HI=0; checksum byte 80
    task automatic test_count256();
        logic [255:0] seen;
        int bad_d;
        wa.delete(); wd.delete();
        seen = '0; bad_d = 0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i)); send_byte(8'h00);
        end
        send_byte(8'h80);
        foreach (wa[i]) begin
            seen[wa[i]] = 1'b1;
            if (wd[i] !== {4'h0, wa[i]}) bad_d++;
        end
        checks++; if (wa.size() != 256) begin errors++; $display("FAIL c256_cnt: got %0d writes want 256", wa.size()); end
        checks++; if (seen !== {256{1'b1}}) begin errors++; $display("FAIL c256_cover: not all addresses written, required all 256"); end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL c256_data: got %0d bad words want 0", bad_d); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL c256_done: got %b want 1", done); end
    endtask

    // Random gaps; checksum 20+03+01+01+02+02+03+03=2F -> D1
    task automatic test_back_to_back();
        logic [7:0] lo[3] = '{8'h01, 8'h02, 8'h03};
        wa.delete(); wd.delete();
        rdy_bad = 0;
        send_byte(8'hA5, $urandom_range(0, 2));
        send_byte(8'h20, $urandom_range(0, 2));
        send_byte(8'h03, $urandom_range(0, 2));
        for (int i = 0; i < 3; i++) begin
            send_byte(lo[i], $urandom_range(0, 2));
            send_byte(lo[i], $urandom_range(0, 2));
            checks++;
            if (we !== 1'b1 || a !== 8'(8'h20 + i) || d !== {lo[i][3:0], lo[i]}) begin
                errors++; $display("FAIL b2b_latency%0d: got we=%b a=%h d=%h want we=1 a=%h", i, we, a, d, 8'(8'h20 + i));
            end
        end
        send_byte(8'hD1, $urandom_range(0, 2));
        checks++; if (wa.size() != 3 || wa[2] !== 8'h22 || wd[1] !== 12'h202) begin errors++; $display("FAIL b2b_writes: got %0d writes want 3", wa.size()); end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL b2b_ready: got %0d cycles with in_ready==we want 0", rdy_bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
    endtask

    task automatic test_format();
        logic [7:0] f[5] = '{8'hA5, 8'h10, 8'h01, 8'h34, 8'h12};
        wa.delete(); wd.delete();
        foreach (f[i]) send_byte(f[i]);
        checks++; if (err !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL fmt_err: got err=%b we=%b want 1 0", err, we); end
        repeat (3) @(posedge clk); #1;
        checks++; if (wa.size() != 0) begin errors++; $display("FAIL fmt_nowrite: got %0d writes want 0", wa.size()); end
        checks++; if (done !== 1'b0 || prog !== 1'b0) begin errors++; $display("FAIL fmt_flags: got done=%b prog=%b want 0 0", done, prog); end
    endtask

    task automatic test_timeout();
        int waited = 0;
        send_byte(8'hA5); send_byte(8'h10);
        repeat (900) @(posedge clk); #1;
        checks++; if (err !== 1'b0 || prog !== 1'b1) begin errors++; $display("FAIL tmo_early: got err=%b prog=%b want 0 1", err, prog); end
        while (err !== 1'b1 && waited < 300) begin @(posedge clk); #1; waited++; end
        checks++; if (err !== 1'b1 || prog !== 1'b0 || cpu_clr !== 1'b1) begin
            errors++; $display("FAIL tmo_abort: got err=%b prog=%b cpu_clr=%b want 1 0 1", err, prog, cpu_clr);
        end
    endtask

    task automatic test_clr_noise();
        logic [7:0] f[9] = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h01, 8'h34, 8'h02, 8'hB9, 8'h00};
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01); send_byte(8'h34);
        checks++; if (prog !== 1'b1 || a !== 8'h10 || d[7:0] !== 8'h34) begin errors++; $display("FAIL clr_pre: got prog=%b a=%h d=%h", prog, a, d); end
        clr = 1'b1;
        #1;
        checks++; if (prog !== 1'b0 || a !== 8'h00 || d !== 12'h000 || cpu_clr !== 1'b1 ||
                      in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL clr_async: got prog=%b a=%h d=%h cpu_clr=%b rdy=%b done=%b err=%b", prog, a, d, cpu_clr, in_ready, done, err);
        end
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;
        wa.delete(); wd.delete();
        for (int i = 0; i < 8; i++) send_byte(f[i]);
        checks++; if (wa.size() != 1 || wa[0] !== 8'h10 || wd[0] !== 12'h234) begin errors++; $display("FAIL noise_write: got %0d writes want one 10=234", wa.size()); end
        checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_clr !== 1'b0) begin errors++; $display("FAIL noise_done: got done=%b err=%b cpu_clr=%b want 1 0 0", done, err, cpu_clr); end
        checks++; if (both_bad != 0) begin errors++; $display("FAIL flags_exclusive: got %0d cycles with done&err want 0", both_bad); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_reload();
        test_bad_chk();
        test_wrap();
        test_count256();
        test_back_to_back();
        test_format();
        test_timeout();
        test_clr_noise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
